sap3_mem_arbiter: RTL

SAP3_MEM_ARBITER -- requirements
Module: sap3_mem_arbiter

---
 rtl/sap3_mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sap3_mem_arbiter.sv
// Two-port arbiter (CPU and external loader) for one single-port RAM: fair alternation on
// conflict, exclusive loader lock, read-return routing and a saturating CPU stall counter.
module sap3_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  input  logic          ext_lock,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          cpu_hold,
  output logic [7:0]    stall_cnt
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  owner_e        last_owner_q, last_owner_d;
  owner_e        rd_tag_q, rd_tag_d;
  logic          rd_pend_q, rd_pend_d;
  logic          locked_q, locked_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ext_rdata_q, ext_rdata_d;
  logic [7:0]    stall_q, stall_d;
  logic          cpu_win;

  // CPU wins a conflict only when the loader owned the RAM last; the lock blocks it outright.
  always_comb begin
    cpu_win  = cpu_req && !locked_q && (!ext_req || (last_owner_q == OWN_EXT));
    cpu_gnt  = rst_n && cpu_win;
    ext_gnt  = rst_n && ext_req && !cpu_win;
    cpu_hold = rst_n && cpu_req && !cpu_win;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // RAM data is only valid for one cycle, so the visible rdata bypasses it and a shadow
  // register keeps the last returned word once rvalid drops.
  always_comb begin
    cpu_rvalid = rd_pend_q && (rd_tag_q == OWN_CPU);
    ext_rvalid = rd_pend_q && (rd_tag_q == OWN_EXT);
    cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    ext_rdata  = ext_rvalid ? mem_rdata : ext_rdata_q;
    stall_cnt  = stall_q;
  end

  always_comb begin
    rd_pend_d    = (cpu_gnt && !cpu_we) || (ext_gnt && !ext_we);
    rd_tag_d     = ext_gnt ? OWN_EXT : OWN_CPU;
    cpu_rdata_d  = cpu_rdata;
    ext_rdata_d  = ext_rdata;
    locked_d     = ext_lock && (locked_q || ext_gnt);
    last_owner_d = last_owner_q;
    if (cpu_gnt) begin
      last_owner_d = OWN_CPU;
    end else if (ext_gnt) begin
      last_owner_d = OWN_EXT;
    end
    stall_d = stall_q;
    if (cpu_hold && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_EXT;
      rd_tag_q     <= OWN_CPU;
      rd_pend_q    <= 1'b0;
      locked_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      stall_q      <= 8'h00;
    end else begin
      last_owner_q <= last_owner_d;
      rd_tag_q     <= rd_tag_d;
      rd_pend_q    <= rd_pend_d;
      locked_q     <= locked_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      stall_q      <= stall_d;
    end
  end

endmodule
